alu_rs: RTL

//  Reservation station and issue scheduler for the single integer ALU. Holds up to RS_DEPTH

---
 rtl/alu_rs_pkg.sv | 14 +
 rtl/alu_rs_select.sv | 53 +++++
 rtl/alu_rs.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Age-ordered select is enabled by defining ALU_RS_AGE_PRIO_EN.
package alu_rs_pkg;

    typedef enum logic [1:0] {
        ENT_FREE,
        ENT_WAIT,
        ENT_READY
    } ent_state_e;

    localparam int unsigned TAG_FREE  = 0;
    localparam int unsigned DATA_FREE = 0;

endpackage

// File: rtl/alu_rs_select.sv
// Issue select for the ALU reservation station: READY vector -> one-hot grant and index.
// With ALU_RS_AGE_PRIO_EN the oldest READY entry wins, otherwise the lowest index.
module alu_rs_select #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0]         ready,
`ifdef ALU_RS_AGE_PRIO_EN
    input  logic [RS_DEPTH*(IDX_W+1)-1:0] ages,
`endif
    output logic [RS_DEPTH-1:0]         grant,
    output logic [IDX_W-1:0]            idx,
    output logic                        valid
);

`ifdef ALU_RS_AGE_PRIO_EN
    localparam int unsigned AGE_W = IDX_W + 1;

    // Stamps span at most RS_DEPTH live values, so the MSB of the difference orders them.
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (ready[i] && (!valid || older(ages[i*AGE_W +: AGE_W], ages[idx*AGE_W +: AGE_W]))) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        if (valid) grant[idx] = 1'b1;
    end
`else
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (ready[i] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        if (valid) grant[idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// Reservation station and issue scheduler for the integer ALU: dispatch, CDB wakeup,
// single registered issue per cycle, branch kill/clear. Optional macro: ALU_RS_AGE_PRIO_EN.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned BTAG_W   = 4,
    parameter int unsigned OP_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispEn,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [DATA_W-1:0] dispValO,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic              dispRdyO,
    input  logic [DATA_W-1:0] dispValT,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic              dispRdyT,
    input  logic [TAG_W-1:0]  dispWrtTag,
    input  logic [31:0]       dispAddr,
    input  logic [BTAG_W-1:0] dispBTag,
    input  logic              aluCdbEn,
    input  logic [TAG_W-1:0]  aluCdbTag,
    input  logic [DATA_W-1:0] aluCdbData,
    input  logic              lsbCdbEn,
    input  logic [TAG_W-1:0]  lsbCdbTag,
    input  logic [DATA_W-1:0] lsbCdbData,
    input  logic              bFreeEn,
    input  logic [1:0]        bFreeNum,
    input  logic              misTaken,
    output logic              rsFull,
    output logic              ALUworkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [TAG_W-1:0]  wrtTag,
    output logic [OP_W-1:0]   opCode,
    output logic [31:0]       instAddr,
    output logic [BTAG_W-1:0] instBranchTag
);

    localparam int unsigned IDX_W = $clog2(RS_DEPTH);

    ent_state_e        state_q [RS_DEPTH], state_d [RS_DEPTH];
    logic              rdy_o_q [RS_DEPTH], rdy_o_d [RS_DEPTH];
    logic              rdy_t_q [RS_DEPTH], rdy_t_d [RS_DEPTH];
    logic [DATA_W-1:0] val_o_q [RS_DEPTH], val_o_d [RS_DEPTH];
    logic [DATA_W-1:0] val_t_q [RS_DEPTH], val_t_d [RS_DEPTH];
    logic [TAG_W-1:0]  tag_o_q [RS_DEPTH], tag_o_d [RS_DEPTH];
    logic [TAG_W-1:0]  tag_t_q [RS_DEPTH], tag_t_d [RS_DEPTH];
    logic [TAG_W-1:0]  wtag_q  [RS_DEPTH], wtag_d  [RS_DEPTH];
    logic [OP_W-1:0]   op_q    [RS_DEPTH], op_d    [RS_DEPTH];
    logic [31:0]       addr_q  [RS_DEPTH], addr_d  [RS_DEPTH];
    logic [BTAG_W-1:0] btag_q  [RS_DEPTH], btag_d  [RS_DEPTH];

    logic              work_en_q, work_en_d;
    logic [DATA_W-1:0] out_o_q, out_o_d, out_t_q, out_t_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic [BTAG_W-1:0] out_btag_q, out_btag_d;

    logic [BTAG_W-1:0]   bmask;
    logic [RS_DEPTH-1:0] kill_vec, ready_vec, grant;
    logic [IDX_W-1:0]    sel_idx, free_idx;
    logic                sel_valid, free_found, disp_fire, issue_fire;

    // Operand snoop: ALU bus has priority over LSB bus on a (illegal) double match.
    function automatic logic [DATA_W:0] snoop(input logic rdy, input logic [TAG_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        if (rdy) return {1'b1, val};
        if (aluCdbEn && aluCdbTag == tag) return {1'b1, aluCdbData};
        if (lsbCdbEn && lsbCdbTag == tag) return {1'b1, lsbCdbData};
        return {1'b0, val};
    endfunction

    always_comb begin
        bmask      = bFreeEn ? (BTAG_W'(1) << bFreeNum) : '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            kill_vec[i]  = misTaken && |(btag_q[i] & bmask);
            ready_vec[i] = (state_q[i] == ENT_READY);
            if (state_q[i] == ENT_FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        rsFull     = !free_found;
        disp_fire  = dispEn && !rsFull && !(misTaken && |(dispBTag & bmask));
        issue_fire = sel_valid && !kill_vec[sel_idx];
    end

`ifdef ALU_RS_AGE_PRIO_EN
    localparam int unsigned AGE_W = IDX_W + 1;
    logic [AGE_W-1:0]          age_q [RS_DEPTH], age_d [RS_DEPTH];
    logic [AGE_W-1:0]          age_cnt_q, age_cnt_d;
    logic [RS_DEPTH*AGE_W-1:0] ages_flat;

    always_comb begin
        age_d     = age_q;
        age_cnt_d = age_cnt_q + AGE_W'(disp_fire);
        ages_flat = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            ages_flat[i*AGE_W +: AGE_W] = age_q[i];
            if (disp_fire && IDX_W'(i) == free_idx) age_d[i] = age_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
            age_cnt_q <= '0;
        end else begin
            age_q     <= age_d;
            age_cnt_q <= age_cnt_d;
        end
    end
`endif

    alu_rs_select #(
        .RS_DEPTH (RS_DEPTH),
        .IDX_W    (IDX_W)
    ) u_select (
        .ready (ready_vec),
`ifdef ALU_RS_AGE_PRIO_EN
        .ages  (ages_flat),
`endif
        .grant (grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_comb begin
        state_d = state_q;
        rdy_o_d = rdy_o_q;
        rdy_t_d = rdy_t_q;
        val_o_d = val_o_q;
        val_t_d = val_t_q;
        tag_o_d = tag_o_q;
        tag_t_d = tag_t_q;
        wtag_d  = wtag_q;
        op_d    = op_q;
        addr_d  = addr_q;
        btag_d  = btag_q;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (state_q[i] != ENT_FREE) begin
                if (kill_vec[i] || grant[i]) begin
                    state_d[i] = ENT_FREE;
                end else begin
                    btag_d[i] = btag_q[i] & ~bmask;
                    {rdy_o_d[i], val_o_d[i]} = snoop(rdy_o_q[i], tag_o_q[i], val_o_q[i]);
                    {rdy_t_d[i], val_t_d[i]} = snoop(rdy_t_q[i], tag_t_q[i], val_t_q[i]);
                    if (rdy_o_d[i] && rdy_t_d[i]) state_d[i] = ENT_READY;
                    else                          state_d[i] = ENT_WAIT;
                end
            end else if (disp_fire && IDX_W'(i) == free_idx) begin
                {rdy_o_d[i], val_o_d[i]} = snoop(dispRdyO, dispTagO, dispValO);
                {rdy_t_d[i], val_t_d[i]} = snoop(dispRdyT, dispTagT, dispValT);
                tag_o_d[i] = dispTagO;
                tag_t_d[i] = dispTagT;
                wtag_d[i]  = dispWrtTag;
                op_d[i]    = dispOp;
                addr_d[i]  = dispAddr;
                btag_d[i]  = dispBTag & ~bmask;
                if (rdy_o_d[i] && rdy_t_d[i]) state_d[i] = ENT_READY;
                else                          state_d[i] = ENT_WAIT;
            end
        end
    end

    always_comb begin
        work_en_d  = issue_fire;
        out_o_d    = out_o_q;
        out_t_d    = out_t_q;
        out_tag_d  = out_tag_q;
        out_op_d   = out_op_q;
        out_addr_d = out_addr_q;
        out_btag_d = out_btag_q;
        if (issue_fire) begin
            out_o_d    = val_o_q[sel_idx];
            out_t_d    = val_t_q[sel_idx];
            out_tag_d  = wtag_q[sel_idx];
            out_op_d   = op_q[sel_idx];
            out_addr_d = addr_q[sel_idx];
            out_btag_d = btag_q[sel_idx] & ~bmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                state_q[i] <= ENT_FREE;
                rdy_o_q[i] <= 1'b0;
                rdy_t_q[i] <= 1'b0;
                val_o_q[i] <= DATA_W'(DATA_FREE);
                val_t_q[i] <= DATA_W'(DATA_FREE);
                tag_o_q[i] <= TAG_W'(TAG_FREE);
                tag_t_q[i] <= TAG_W'(TAG_FREE);
                wtag_q[i]  <= TAG_W'(TAG_FREE);
                op_q[i]    <= '0;
                addr_q[i]  <= '0;
                btag_q[i]  <= '0;
            end
            work_en_q  <= 1'b0;
            out_o_q    <= DATA_W'(DATA_FREE);
            out_t_q    <= DATA_W'(DATA_FREE);
            out_tag_q  <= TAG_W'(TAG_FREE);
            out_op_q   <= '0;
            out_addr_q <= '0;
            out_btag_q <= '0;
        end else begin
            state_q    <= state_d;
            rdy_o_q    <= rdy_o_d;
            rdy_t_q    <= rdy_t_d;
            val_o_q    <= val_o_d;
            val_t_q    <= val_t_d;
            tag_o_q    <= tag_o_d;
            tag_t_q    <= tag_t_d;
            wtag_q     <= wtag_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            btag_q     <= btag_d;
            work_en_q  <= work_en_d;
            out_o_q    <= out_o_d;
            out_t_q    <= out_t_d;
            out_tag_q  <= out_tag_d;
            out_op_q   <= out_op_d;
            out_addr_q <= out_addr_d;
            out_btag_q <= out_btag_d;
        end
    end

    assign ALUworkEn     = work_en_q;
    assign operandO      = out_o_q;
    assign operandT      = out_t_q;
    assign wrtTag        = out_tag_q;
    assign opCode        = out_op_q;
    assign instAddr      = out_addr_q;
    assign instBranchTag = out_btag_q;

endmodule
